freq_gate_counter: RTL and testbench
====================================

# freq_gate_counter

Measurement front end of the frequency counter: synchronises the external input signal, counts its rising edges over a fixed gate window of `clk` cycles, and presents the latched count as a binary value. `bin_to_bcd` sits directly downstream and converts `count_out` into the eight decimal digits for the display. With `GATE_CYCLES` equal to the clock frequency, `count_out` reads directly in Hz.

## Interface
- `GATE_CYCLES`, 50_000_000: gate window length in `clk` cycles; legal range ≥ 4.
- `CNT_W`, 27: width of the edge counter and of `count_out`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `count_out`  out  CNT_W  edge count of the last completed gate window.
- `count_valid`  out  1  one-cycle pulse; `count_out` has just been updated.
- `overflow`  out  1  the last completed window saturated the counter.
- `hold`  in  1  freezes the result outputs. Present only with `FREQ_CNT_HOLD_EN`.

## Operation
- Synchroniser: two flip-flops, `s1` and `s2`, then `s3` for edge detection. `edge_p = s2 & ~s3`.
- State machine with two states, `FLUSH` and `GATE`.
  - `FLUSH`: entered on reset. Lasts exactly 3 cycles while the synchroniser chain fills. No edges are counted; `gate_cnt` is held at 0. Then moves to `GATE`.
  - `GATE`: `gate_cnt` counts 0 to `GATE_CYCLES-1` and wraps. Each cycle with `edge_p` high increments `edge_cnt`.
  - On the last gate cycle (`gate_cnt == GATE_CYCLES-1`):
    - `count_out` loads `edge_cnt + edge_p`; the edge on the final cycle belongs to the closing window.
    - `overflow` loads the window's saturation flag.
    - `count_valid` pulses.
    - `edge_cnt` and the saturation flag clear, and the next window starts on the following cycle with no dead cycle.
  - The state machine stays in `GATE` until reset.
- Arithmetic:
  - `edge_cnt` saturates at 2^CNT_W−1 and never wraps.
  - An increment attempted at the maximum value sets the window's saturation flag; the loaded value is then 2^CNT_W−1.
  - `gate_cnt` width is `$clog2(GATE_CYCLES)`.
- Reset values:
  - `count_out` = 0, `count_valid` = 0, `overflow` = 0.
  - `s1`, `s2`, `s3` = 0; `edge_cnt` = 0; `gate_cnt` = 0; state = `FLUSH`.
- Reset mid-window: the partial count is discarded. Outputs return to their reset values on the next edge and the sequence restarts from `FLUSH`.

## Timing
- A rising edge of `sig_in` sampled on cycle n produces `edge_p` high on cycle n+2; it is counted at the edge ending that cycle.
- After reset deasserts, the first window spans cycles 3 to `GATE_CYCLES`+2. The first `count_valid` appears in cycle `GATE_CYCLES`+3.
- `count_valid` then recurs every `GATE_CYCLES` cycles exactly. It is never high two cycles in a row.
- `count_out` and `overflow` change only in the cycle where `count_valid` is high. They are stable at all other times.
- Maximum measurable rate is `clk`/2: `sig_in` must be low for ≥1 cycle and high for ≥1 cycle. Faster inputs under-count silently.

## Configuration
- `FREQ_CNT_HOLD_EN` defined:
  - Adds the `hold` port.
  - At a window end with `hold` = 1, `count_out` and `overflow` keep their values and `count_valid` stays low.
  - Edge counting and gate timing continue unaffected.
- `FREQ_CNT_HOLD_EN` undefined: no `hold` port; every window end updates the outputs.

## Structure
- Shared package `freq_pkg`:
  - `CNT_W_DEF` = 27 and `CLK_HZ_DEF` = 50_000_000, also used by `bin_to_bcd` and the top level.
  - Enum `gate_state_t {FLUSH, GATE}`.
- One sub-module, `sig_sync_edge`: 2-FF synchroniser plus rising-edge detector; `clk`, `rst`, `sig_in` in, `edge_p` out.
- Gate and edge counters stay in `freq_gate_counter`.

## Test plan
All scenarios use `GATE_CYCLES` = 100 and `CNT_W` = 27 unless stated.
- Square wave, period 10 clk (5 high, 5 low), started before reset release → every `count_valid` after the first window gives `count_out` = 10; first valid pulse at cycle 103.
- `sig_in` held high through reset and after → no false count; `count_out` = 0 on every valid pulse.
- Maximum rate, toggle every cycle (period 2) → `count_out` = 50 each window; `overflow` = 0.
- Saturation, with `CNT_W` = 4 and period 2 (50 edges) → `count_out` = 15, `overflow` = 1; then stop `sig_in` → next window `count_out` = 0, `overflow` = 0.
- Single edge placed so `edge_p` falls on the final gate cycle → counted in the closing window (`count_out` = 1); the next window gives 0.
- `rst` pulsed 40 cycles into a window, then with `FREQ_CNT_HOLD_EN` set `hold` = 1 across one window end → outputs clear to 0 one cycle after `rst`; the held window produces no `count_valid` and `count_out` keeps its last value.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency counter: default widths, clock rate and gate FSM states.
package freq_pkg;

  localparam int CNT_W_DEF    = 27;
  localparam int CLK_HZ_DEF   = 50_000_000;
  localparam int FLUSH_CYCLES = 3;

  typedef enum logic {
    FLUSH = 1'b0,
    GATE  = 1'b1
  } gate_state_t;

endpackage

// File: rtl/freq_gate_counter_sig_sync_edge.sv
// Two-flop synchroniser for the asynchronous measured signal plus a rising-edge detector.
module sig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_p
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p = s2 & ~s3;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over GATE_CYCLES clocks.
// Optional FREQ_CNT_HOLD_EN adds a hold input that freezes the result outputs.
//
//   state | meaning
//   FLUSH | 3 cycles after reset while the synchroniser fills; nothing counted
//   GATE  | free-running gate windows, result latched on each window's last cycle
module freq_gate_counter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = CLK_HZ_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
`ifdef FREQ_CNT_HOLD_EN
  input  logic             hold,
`endif
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
);

  localparam int                GATE_W     = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE   = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  gate_state_t       state;
  logic [1:0]        flush_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat_flag;

  logic              edge_p;
  logic              at_max;
  logic              update_en;
  logic [CNT_W-1:0]  close_cnt;
  logic              close_ovf;

  sig_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .edge_p (edge_p)
  );

  // An edge arriving on the final gate cycle still belongs to the closing window.
  assign at_max    = (edge_cnt == CNT_MAX);
  assign close_cnt = (edge_p && !at_max) ? edge_cnt + CNT_ONE : edge_cnt;
  assign close_ovf = sat_flag | (edge_p & at_max);

`ifdef FREQ_CNT_HOLD_EN
  assign update_en = ~hold;
`else
  assign update_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FLUSH;
      flush_cnt   <= 2'd0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      sat_flag    <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        FLUSH: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_flag <= 1'b0;
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= 2'd0;
            state     <= GATE;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
            if (update_en) begin
              count_out   <= close_cnt;
              overflow    <= close_ovf;
              count_valid <= 1'b1;
            end
          end else begin
            gate_cnt <= gate_cnt + GATE_ONE;
            if (edge_p) begin
              if (at_max) begin
                sat_flag <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + CNT_ONE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter (GATE_CYCLES = 100); hold scenario runs when FREQ_CNT_HOLD_EN is defined.
module tb_freq_gate_counter;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        sig_in = 1'b0;
  logic        hold   = 1'b0;
  logic [26:0] count_out;
  logic        count_valid;
  logic        overflow;
  logic [3:0]  sat_count;
  logic        sat_valid;
  logic        sat_ovf;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   ph      = 0;
  int   per     = 0;
  logic sig_lvl = 1'b0;

  always #5 clk = ~clk;

  freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(27)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
`ifdef FREQ_CNT_HOLD_EN
    .hold        (hold),
`endif
    .count_out   (count_out),
    .count_valid (count_valid),
    .overflow    (overflow)
  );

  freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
`ifdef FREQ_CNT_HOLD_EN
    .hold        (1'b0),
`endif
    .count_out   (sat_count),
    .count_valid (sat_valid),
    .overflow    (sat_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ph++;
    if (per == 0) sig_in = sig_lvl;
    else          sig_in = ((ph % per) < (per / 2));
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // After this returns the bench sits in cycle 0, the first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Square wave, period 10, running through reset
    per = 10;
    do_reset();
    check("rst_count_out", 64'(count_out), 64'd0);
    check("rst_valid", 64'(count_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    run_to(102);
    check("sq_valid_c102", 64'(count_valid), 64'd0);
    run_to(103);
    check("sq_valid_c103", 64'(count_valid), 64'd1);
    run_to(104);
    check("sq_valid_c104", 64'(count_valid), 64'd0);
    run_to(202);
    check("sq_valid_c202", 64'(count_valid), 64'd0);
    run_to(203);
    check("sq_valid_c203", 64'(count_valid), 64'd1);
    check("sq_count_w2", 64'(count_out), 64'd10);
    run_to(250);
    check("sq_count_stable", 64'(count_out), 64'd10);
    run_to(303);
    check("sq_valid_c303", 64'(count_valid), 64'd1);
    check("sq_count_w3", 64'(count_out), 64'd10);

    // Input held high through and after reset
    per = 0;
    sig_lvl = 1'b1;
    do_reset();
    run_to(103);
    check("high_valid", 64'(count_valid), 64'd1);
    check("high_count_w1", 64'(count_out), 64'd0);
    run_to(203);
    check("high_count_w2", 64'(count_out), 64'd0);

    // Maximum rate plus 4-bit saturation
    per = 2;
    do_reset();
    run_to(103);
    check("max_valid", 64'(count_valid), 64'd1);
    check("max_count", 64'(count_out), 64'd50);
    check("max_overflow", 64'(overflow), 64'd0);
    check("sat_valid", 64'(sat_valid), 64'd1);
    check("sat_count", 64'(sat_count), 64'd15);
    check("sat_overflow", 64'(sat_ovf), 64'd1);
    run_to(143);
    check("sat_ovf_stable", 64'(sat_ovf), 64'd1);

    // Reset 40 cycles into the second window
    rst = 1'b1;
    step();
    check("midrst_count", 64'(count_out), 64'd0);
    check("midrst_valid", 64'(count_valid), 64'd0);
    check("midrst_sat_count", 64'(sat_count), 64'd0);
    check("midrst_sat_ovf", 64'(sat_ovf), 64'd0);
    rst = 1'b0;
    cyc = 0;
    run_to(102);
    check("restart_valid_c102", 64'(count_valid), 64'd0);
    run_to(103);
    check("restart_valid_c103", 64'(count_valid), 64'd1);
    check("restart_count", 64'(count_out), 64'd50);
    check("restart_sat_ovf", 64'(sat_ovf), 64'd1);
    run_to(110);
    per = 0;
    sig_lvl = 1'b0;
    run_to(303);
    check("stop_valid", 64'(count_valid), 64'd1);
    check("stop_count", 64'(count_out), 64'd0);
    check("stop_overflow", 64'(overflow), 64'd0);
    check("stop_sat_count", 64'(sat_count), 64'd0);
    check("stop_sat_ovf", 64'(sat_ovf), 64'd0);

    // Single edge whose edge_p lands on the last gate cycle (cycle 102)
    per = 0;
    sig_lvl = 1'b0;
    do_reset();
    run_to(100);
    sig_lvl = 1'b1;
    sig_in  = 1'b1;
    run_to(103);
    check("last_edge_valid", 64'(count_valid), 64'd1);
    check("last_edge_count", 64'(count_out), 64'd1);
    run_to(105);
    sig_lvl = 1'b0;
    run_to(203);
    check("after_last_count", 64'(count_out), 64'd0);

`ifdef FREQ_CNT_HOLD_EN
    // Hold across one window end
    per = 10;
    hold = 1'b0;
    do_reset();
    run_to(203);
    check("hold_pre_count", 64'(count_out), 64'd10);
    run_to(210);
    per = 2;
    run_to(250);
    hold = 1'b1;
    run_to(303);
    check("hold_valid", 64'(count_valid), 64'd0);
    check("hold_count", 64'(count_out), 64'd10);
    run_to(310);
    hold = 1'b0;
    run_to(403);
    check("unhold_valid", 64'(count_valid), 64'd1);
    check("unhold_count", 64'(count_out), 64'd50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
